// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone-classic arbiter onto one single-port BRAM; ack + read data two cycles after a request is sampled.
// Backpressure: a losing master is stalled (no ack) until the owner releases; owner held cyc without stb times out after HOLD_MAX.
module wb_bram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12,
    parameter int HOLD_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic                  m0_ack,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic                  m1_ack,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [1:0]            grant,
    output logic                  timeout
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, WAIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;  // 1 = master 1 owned last
    logic [HW-1:0]         hold_q, hold_d;
    logic                  timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  ack_int;

    logic                  req0, req1;
    logic                  g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0] g_dat;

    assign req0  = m0_cyc & m0_stb;
    assign req1  = m1_cyc & m1_stb;
    assign g_cyc = grant_q[1] ? m1_cyc   : m0_cyc;
    assign g_stb = grant_q[1] ? m1_stb   : m0_stb;
    assign g_we  = grant_q[1] ? m1_we    : m0_we;
    assign g_adr = grant_q[1] ? m1_adr   : m0_adr;
    assign g_dat = grant_q[1] ? m1_dat_o : m0_dat_o;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        addr_d       = addr_q;
        din_d        = din_q;
        bram_we      = 1'b0;
        bram_addr    = addr_q;
        bram_din     = din_q;
        ack_int      = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                // On a tie the master that did not own the bus last wins
                if (req0 && (!req1 || last_grant_q)) begin
                    grant_d      = 2'b01;
                    last_grant_d = 1'b0;
                    state_d      = ACCESS;
                end else if (req1) begin
                    grant_d      = 2'b10;
                    last_grant_d = 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                bram_addr = g_adr;
                bram_din  = g_dat;
                addr_d    = g_adr;
                din_d     = g_dat;
                hold_d    = '0;
                if (g_stb) begin
                    bram_we = g_we;
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                end
            end
            ACK: begin
                ack_int = 1'b1;
                hold_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!g_cyc) begin
                    grant_d = 2'b00;
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (g_stb) begin
                    hold_d  = '0;
                    state_d = ACCESS;
                end else if (hold_q == HW'(HOLD_MAX)) begin
                    grant_d   = 2'b00;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            hold_q       <= '0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            timeout_q    <= timeout_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    assign m0_ack   = ack_int & grant_q[0];
    assign m1_ack   = ack_int & grant_q[1];
    assign m0_dat_i = m0_ack ? bram_dout : '0;
    assign m1_dat_i = m1_ack ? bram_dout : '0;
    assign grant    = grant_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Bench for wb_bram_arbiter: directed scenarios plus random transaction rounds against a transaction-level model.
module tb_wb_bram_arbiter;

    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [9:0]  m_adr [2];
    logic [11:0] m_dat_o [2];
    logic [11:0] m0_dat_i, m1_dat_i;
    logic        m0_ack, m1_ack;
    logic        bram_we;
    logic [9:0]  bram_addr;
    logic [11:0] bram_din;
    logic [11:0] bram_dout;
    logic [1:0]  grant;
    logic        timeout;

    logic [11:0] mem     [1024];
    logic [11:0] exp_mem [1024];

    int checks = 0;
    int errors = 0;
    int last_win = 1;

    always #5 clk = ~clk;

    wb_bram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(12), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
        .m0_dat_o(m_dat_o[0]), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
        .m1_dat_o(m_dat_o[1]), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .grant(grant), .timeout(timeout)
    );

    // Read-first synchronous BRAM
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    function automatic logic ack_of(input int i);
        return (i == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [11:0] dat_of(input int i);
        return (i == 1) ? m1_dat_i : m0_dat_i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop(input int i);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
        m_we[i]  = 1'b0;
    endtask

    // One arbitration round from IDLE; each requesting master does a single access then releases.
    task automatic round(input logic [1:0] req, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [11:0] d0, input logic [11:0] d1);
        logic [9:0]  adr [2];
        logic [11:0] dat [2];
        logic [11:0] exp_rd [2];
        int          exp_ack [2];
        int          order [2];
        int          i;
        bit          seen [2];
        adr[0] = a0; adr[1] = a1; dat[0] = d0; dat[1] = d1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        exp_ack[0] = -1; exp_ack[1] = -1;
        order[1] = -1;
        if (req == 2'b11) begin
            order[0] = (last_win == 1) ? 0 : 1;
            order[1] = 1 - order[0];
        end else begin
            order[0] = req[1] ? 1 : 0;
        end
        // Owner acks 2 cycles after request; a waiting master needs release (2) + IDLE (1) + 2 more
        for (int k = 0; k < 2; k++) begin
            i = order[k];
            if (i >= 0) begin
                exp_ack[i] = (k == 0) ? 2 : 6;
                if (we[i]) exp_mem[adr[i]] = dat[i];
                else       exp_rd[i] = exp_mem[adr[i]];
                last_win = i;
            end
        end
        for (int j = 0; j < 2; j++) begin
            seen[j] = 1'b0;
            if (req[j]) begin
                m_cyc[j] = 1'b1; m_stb[j] = 1'b1; m_we[j] = we[j];
                m_adr[j] = adr[j]; m_dat_o[j] = dat[j];
            end
        end
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                seen[j] = ack_of(j);
                chk($sformatf("ack m%0d c%0d", j, c), 32'(seen[j]), 32'(req[j] && c == exp_ack[j]));
                if (!seen[j]) chk($sformatf("dat_i idle m%0d c%0d", j, c), 32'(dat_of(j)), 32'h0);
                else if (!we[j]) chk($sformatf("rdata m%0d", j), 32'(dat_of(j)), 32'(exp_rd[j]));
                if (req[j] && c == exp_ack[j] - 1) begin
                    chk($sformatf("grant m%0d", j), 32'(grant), (j == 0) ? 32'h1 : 32'h2);
                    chk($sformatf("bram_we m%0d", j), 32'(bram_we), 32'(we[j]));
                    chk($sformatf("bram_addr m%0d", j), 32'(bram_addr), 32'(adr[j]));
                    chk($sformatf("bram_din m%0d", j), 32'(bram_din), 32'(dat[j]));
                end
            end
            @(posedge clk); #1;
            for (int j = 0; j < 2; j++) if (seen[j]) drop(j);
        end
    endtask

    logic [1:0]  rq, rw;
    logic [11:0] bd [3];
    logic [11:0] td, pd;
    logic        a0s, a1s;
    int          m1_cnt, m1_last, m0_ackc, t_cnt, t_cyc, m1_ackc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            drop(j); m_adr[j] = '0; m_dat_o[j] = '0;
        end
        for (int k = 0; k < 1024; k++) begin
            mem[k] = 12'(k * 7);
            exp_mem[k] = 12'(k * 7);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst m0_ack", 32'(m0_ack), 32'h0);
        chk("rst m1_ack", 32'(m1_ack), 32'h0);
        chk("rst m0_dat_i", 32'(m0_dat_i), 32'h0);
        chk("rst m1_dat_i", 32'(m1_dat_i), 32'h0);
        chk("rst bram_we", 32'(bram_we), 32'h0);
        chk("rst bram_addr", 32'(bram_addr), 32'h0);
        chk("rst bram_din", 32'(bram_din), 32'h0);
        chk("rst timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests alternate, M0 first after reset
        round(2'b11, 2'b00, 10'h001, 10'h002, 12'h0, 12'h0);
        round(2'b11, 2'b11, 10'h100, 10'h101, 12'h5A5, 12'h3C3);

        // M0 write then read back
        round(2'b01, 2'b01, 10'h005, 10'h000, 12'hABC, 12'h0);
        round(2'b01, 2'b00, 10'h005, 10'h000, 12'h0, 12'h0);

        // M1 read while M0 idle
        round(2'b10, 2'b00, 10'h000, 10'h005, 12'h0, 12'h0);

        // M1 locked 3-beat write burst; M0 read of the middle word waits
        for (int k = 0; k < 3; k++) bd[k] = 12'($urandom);
        m1_cnt = 0; m1_last = -1; m0_ackc = -1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 10'h3FD; m_dat_o[1] = bd[0];
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 9) chk($sformatf("burst grant c%0d", c), 32'(grant), 32'h2);
            a1s = m1_ack; a0s = m0_ack;
            if (a1s) begin m1_cnt++; m1_last = c; end
            if (a0s) begin
                m0_ackc = c;
                chk("burst m0 rdata", 32'(m0_dat_i), 32'(bd[1]));
            end
            @(posedge clk); #1;
            if (c == 0) begin
                m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 10'h3FE;
            end
            if (a1s) begin
                if (m1_cnt < 3) begin
                    m_adr[1] = 10'(10'h3FD + m1_cnt);
                    m_dat_o[1] = bd[m1_cnt];
                end else drop(1);
            end
            if (a0s) drop(0);
        end
        chk("burst m1 acks", 32'(m1_cnt), 32'd3);
        chk("burst m1 last ack", 32'(m1_last), 32'd8);
        chk("burst m0 ack cycle", 32'(m0_ackc), 32'd12);
        for (int k = 0; k < 3; k++) exp_mem[10'h3FD + k] = bd[k];
        last_win = 0;

        // M0 writes then idles on the bus with cyc high; M1 waits for the forced release
        td = 12'($urandom);
        t_cnt = 0; t_cyc = -1; m1_ackc = -1; m0_ackc = -1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 10'h020; m_dat_o[0] = td;
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            a0s = m0_ack; a1s = m1_ack;
            if (timeout) begin t_cnt++; t_cyc = c; end
            if (a0s) m0_ackc = c;
            if (a1s) begin
                m1_ackc = c;
                chk("timeout m1 rdata", 32'(m1_dat_i), 32'(td));
            end
            if (c == 2 + 1 + HOLD) chk("timeout grant held", 32'(grant), 32'h1);
            if (c == 2 + 2 + HOLD) chk("timeout grant released", 32'(grant), 32'h0);
            if (c == 2 + 3 + HOLD) chk("timeout m1 granted", 32'(grant), 32'h2);
            @(posedge clk); #1;
            if (a0s) m_stb[0] = 1'b0;
            if (c == 2) begin
                m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 10'h020;
            end
            if (t_cyc == c) drop(0);
            if (a1s) drop(1);
        end
        chk("timeout m0 ack", 32'(m0_ackc), 32'd2);
        chk("timeout pulses", 32'(t_cnt), 32'd1);
        chk("timeout cycle", 32'(t_cyc), 32'(2 + 2 + HOLD));
        chk("timeout m1 ack", 32'(m1_ackc), 32'(2 + 4 + HOLD));
        exp_mem[10'h020] = td;
        last_win = 1;

        // Reset asserted during the ACCESS cycle of an M0 write must not commit it
        pd = 12'($urandom);
        round(2'b01, 2'b01, 10'h010, 10'h000, pd, 12'h0);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 10'h010; m_dat_o[0] = ~pd;
        @(posedge clk); #1;
        chk("rst-access we before", 32'(bram_we), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst-access we", 32'(bram_we), 32'h0);
        chk("rst-access grant", 32'(grant), 32'h0);
        chk("rst-access addr", 32'(bram_addr), 32'h0);
        drop(0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_win = 1;
        m0_ackc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m0_ack) m0_ackc++;
        end
        chk("rst-access no ack", 32'(m0_ackc), 32'h0);
        @(posedge clk); #1;
        round(2'b01, 2'b00, 10'h010, 10'h000, 12'h0, 12'h0);

        // Random rounds on a small address window to provoke collisions
        for (int r = 0; r < 40; r++) begin
            rq = 2'($urandom_range(1, 3));
            rw = 2'($urandom);
            round(rq, rw, 10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)),
                  12'($urandom), 12'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bram_arbiter.md
WB_BRAM_ARBITER -- requirements
Module: wb_bram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, BRAM/Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 12, BRAM/Wishbone data width.
REQ-003 Parameter HOLD_MAX, default 16, max idle cycles a granted master may hold cyc without stb.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 m0_cyc, m0_stb, m0_we  input  1 each  Wishbone classic master 0 controls.
REQ-007 m0_adr  input  ADDR_WIDTH  master 0 address; m0_dat_o  input  DATA_WIDTH  master 0 write data.
REQ-008 m0_dat_i  output  DATA_WIDTH  read data to master 0; m0_ack  output  1  ack to master 0.
REQ-009 m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o, m1_dat_i, m1_ack  same directions/widths as master 0, for master 1.
REQ-010 bram_we  output  1  BRAM write enable.
REQ-011 bram_addr  output  ADDR_WIDTH; bram_din  output  DATA_WIDTH; bram_dout  input  DATA_WIDTH (1-cycle synchronous read).
REQ-012 grant  output  2  one-hot owner {m1,m0}; 2'b00 = none.
REQ-013 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states IDLE, ACCESS, ACK, WAIT; reset state IDLE.
REQ-015 IDLE: request = mX_cyc & mX_stb; single requester wins; both requesting -> winner is the master not equal to last_grant.
REQ-016 last_grant register resets to master 1, so master 0 wins first simultaneous request; updated on every new grant.
REQ-017 IDLE with request: grant registered at next edge, state -> ACCESS; no request: stay IDLE, grant = 00.
REQ-018 ACCESS: bram_addr = granted adr, bram_din = granted dat_o, bram_we = granted we & stb; state -> ACK.
REQ-019 Outside ACCESS: bram_we = 0; bram_addr/bram_din hold last driven value.
REQ-020 ACK: granted ack = 1 for exactly one cycle; granted dat_i = bram_dout; state -> WAIT.
REQ-021 Latency: request sampled in cycle N (IDLE) -> BRAM access cycle N+1 -> ack and read data cycle N+2.
REQ-022 Non-granted master: ack = 0, dat_i = 0 at all times; its requests wait, never dropped by arbiter.
REQ-023 WAIT: granted cyc = 0 -> grant cleared, state -> IDLE; cyc & stb -> ACCESS (locked burst, no re-arbitration); cyc & !stb -> stay, hold counter increments.
REQ-024 Hold counter cleared on entry to WAIT and on leaving WAIT; at count == HOLD_MAX: grant cleared, timeout = 1 for one cycle, state -> IDLE.
REQ-025 Protocol violation: granted stb low in ACCESS -> bram_we = 0, no ack, state -> WAIT.
REQ-026 Granted cyc drops in ACCESS or ACK -> access completes (write committed; ack still issued), release in following WAIT.
REQ-027 Back-to-back: after release to IDLE, other pending master granted on next edge; one IDLE cycle minimum between owners.
REQ-028 Address/data pass through unchanged, no width conversion; address wrap handled by BRAM.

Reset
REQ-029 rst_n low: immediately state = IDLE, grant = 00, last_grant = master 1, hold counter = 0, all acks 0, all dat_i 0, bram_we 0, bram_addr 0, bram_din 0, timeout 0.
REQ-030 Reset during ACCESS suppresses the write at that edge; no ack issued after reset release.
REQ-031 First grant possible at first rising edge after rst_n deassertion.

Verification
REQ-032 M0 write adr 0x005 data 0xABC, then read 0x005 -> bram_we high one cycle in ACCESS; read ack at N+2 with m0_dat_i = 0xABC.
REQ-033 Both masters request in same cycle after reset -> M0 granted first; on M0 release M1 granted; next simultaneous request -> M0 wins (alternation).
REQ-034 M1 holds cyc, 3-beat burst to 0x3FD..0x3FF -> grant stays 10 throughout, 3 acks, M0 request stalled until cyc drops.
REQ-035 M0 holds cyc with stb low for HOLD_MAX=16 cycles -> timeout pulses once, grant -> 00, pending M1 granted next edge.
REQ-036 rst_n asserted in ACCESS of M0 write to 0x010 -> bram_we 0 immediately, no ack; later read of 0x010 returns prior contents.
REQ-037 M1 reading while M0 idle -> m0_ack = 0 and m0_dat_i = 0 every cycle.
